// File: rtl/frame_scanout.sv
// frame_scanout: 640x480@60 VGA scanout of a 160x120 3-bit framebuffer with 4x4 pixel replication.
// A half-rate phase enable derives the 25 MHz pixel clock; all outputs update as VGA_CLK falls.
module frame_scanout (
   input  logic        clk,
   input  logic        reset,
   output logic [14:0] rd_addr,
   input  logic [2:0]  rd_data,
   output logic [9:0]  VGA_R,
   output logic [9:0]  VGA_G,
   output logic [9:0]  VGA_B,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N,
   output logic        VGA_CLK,
   output logic        frame_start
);
   logic        r_ph;
   logic [9:0]  r_h;
   logic [9:0]  r_v;
   logic        w_active;
   logic        w_h_last;
   logic        w_v_last;
   logic [14:0] w_y;
   logic [14:0] w_addr;
   always_comb begin
      w_active = (r_h < 10'd640) && (r_v < 10'd480);
      w_h_last = r_h == 10'd799;
      w_v_last = r_v == 10'd524;
      w_y      = {8'd0, r_v[8:2]};
      w_addr   = (w_y << 7) + (w_y << 5) + {7'd0, r_h[9:2]};
   end
   // Address is issued on the ph=0 edge so the RAM word is ready for the following pixel edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ph        <= 1'b0;
         r_h         <= 10'd0;
         r_v         <= 10'd0;
         rd_addr     <= 15'd0;
         VGA_R       <= 10'd0;
         VGA_G       <= 10'd0;
         VGA_B       <= 10'd0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         r_ph        <= ~r_ph;
         frame_start <= 1'b0;
         if (!r_ph) begin
            rd_addr <= w_active ? w_addr : 15'd0;
         end else begin
            VGA_R       <= w_active ? {10{rd_data[2]}} : 10'd0;
            VGA_G       <= w_active ? {10{rd_data[1]}} : 10'd0;
            VGA_B       <= w_active ? {10{rd_data[0]}} : 10'd0;
            VGA_HS      <= !((r_h >= 10'd656) && (r_h <= 10'd751));
            VGA_VS      <= !((r_v == 10'd490) || (r_v == 10'd491));
            VGA_BLANK_N <= w_active;
            frame_start <= (r_h == 10'd0) && (r_v == 10'd0);
            r_h         <= w_h_last ? 10'd0 : r_h + 10'd1;
            if (w_h_last)
               r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
         end
      end
   end
   assign VGA_SYNC_N = 1'b1;
   assign VGA_CLK    = r_ph;
endmodule

// File: doc/frame_scanout.md
FRAME_SCANOUT -- requirements
Module: frame_scanout

Interface
REQ-001 Parameters: none; 640x480@60 timing, 160x120 source, 3-bit colour are fixed.
REQ-002 clk  input  1  system clock (50 MHz).
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rd_addr  output  15  framebuffer read address, y*160+x, registered.
REQ-005 rd_data  input  3  framebuffer word {R,G,B}, valid one clk after rd_addr changes (synchronous RAM).
REQ-006 VGA_R, VGA_G, VGA_B  output  10 each  DAC colour, registered.
REQ-007 VGA_HS, VGA_VS  output  1 each  syncs, active low, registered.
REQ-008 VGA_BLANK_N  output  1  high in the active area only, registered.
REQ-009 VGA_SYNC_N  output  1  constant 1.
REQ-010 VGA_CLK  output  1  25 MHz pixel clock to the DAC.
REQ-011 frame_start  output  1  one-clk pulse at the start of each frame.

Function
REQ-012 The phase flop ph SHALL toggle every clk; pix_en = (ph==1); VGA_CLK = ph.
REQ-013 The counters h_cnt (0..799) and v_cnt (0..524) SHALL advance only on clk edges with pix_en=1.
REQ-014 h_cnt=799 SHALL wrap to 0 and increment v_cnt; at h_cnt=799 and v_cnt=524, both SHALL wrap to 0.
REQ-015 The active area SHALL be h_cnt<640 and v_cnt<480.
REQ-016 HS SHALL be low for h_cnt 656..751; VS SHALL be low for v_cnt 490..491.
REQ-017 Source pixel SHALL be x=h_cnt[9:2] (0..159) and y=v_cnt[8:2] (0..119), giving 4x4 replication.
REQ-018 Address SHALL be (y<<7)+(y<<5)+x, computed in 15 bits with no overflow (max 19199).
REQ-019 On a clk edge with pix_en=0:
- If active: rd_addr <= address of the current (h_cnt,v_cnt).
- Otherwise: rd_addr <= 0.
REQ-020 On a clk edge with pix_en=1, all of the following SHALL be registered from the same pre-increment (h_cnt,v_cnt), then the counters advance:
- VGA_R <= {10{rd_data[2]}}, VGA_G <= {10{rd_data[1]}}, VGA_B <= {10{rd_data[0]}} when active, else 0.
- VGA_HS, VGA_VS, VGA_BLANK_N per REQ-015/016.
REQ-021 Outputs SHALL change on the edge where ph goes 1->0, so data is stable 20 ns before each VGA_CLK rise.
REQ-022 frame_start SHALL be 1 for exactly the one clk following the pix_en edge at which h_cnt=0 and v_cnt=0 are registered.
REQ-023 rd_data SHALL be sampled only on pix_en=1 edges; values at other times have no effect.
REQ-024 Colour SHALL NOT be output during blanking even if rd_data is non-zero.

Reset
REQ-025 While reset=1, all state SHALL clear immediately:
- ph=0, h_cnt=0, v_cnt=0, rd_addr=0.
- VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, frame_start=0.
REQ-026 Assertion mid-frame SHALL abort the frame with no partial-line completion.
REQ-027 After release, the first pix_en edge is the 2nd clk; scanout SHALL restart at (0,0).

Verification
REQ-028 Reset release, rd_data=3'b101 constant -> in the active area VGA_R=10'h3FF, VGA_G=0, VGA_B=10'h3FF, BLANK_N=1; in blanking all 0 and BLANK_N=0.
REQ-029 Free run -> HS period 1600 clk, HS low 192 clk; VS period 840000 clk, VS low 3200 clk; frame_start once per 840000 clk.
REQ-030 Address trace -> rd_addr=0 for h_cnt 0..3 of lines 0..3; rd_addr=19199 for h_cnt 636..639 on v_cnt 476..479; rd_addr=0 throughout blanking.
REQ-031 Model RAM with 1-clk latency holding a unique pattern per address -> every active output pixel equals RAM[y*160+x]; no off-by-one at x=159 or at line boundaries.
REQ-032 Assert reset at h_cnt=300, v_cnt=200 -> outputs at reset values in the same cycle; after release the next HS falling edge occurs 1312 clk after the first pix_en edge.
REQ-033 Check phase alignment -> every change on RGB/HS/VS/BLANK_N coincides with a VGA_CLK falling edge, never a rising edge.
